mxint8_block_seq: RTL and testbench
===================================

// Module: mxint8_block_seq
// PURPOSE
// - Sequencer for the combinational MXINT8 block-sum datapath (mxint8_sum).
// - Collects one MX block (shared scale + BLOCK_SIZE elements) over a narrow LANES-wide valid/ready stream.
// - Holds the assembled block stable on the datapath operands for one cycle, registers the FP32 result, and
//   presents it on a valid/ready output channel.
// PARAMETERS
// - BLOCK_SIZE  32  elements per MX block; must equal the datapath's BLOCK_SIZE
// - LANES       4   elements per input beat; BLOCK_SIZE % LANES == 0; BEATS = BLOCK_SIZE/LANES
// - ELEM_W      8   MXINT8 element width
// - SCALE_W     8   shared-scale width
// PORTS
// - i_clk            in   1                 clock; all state changes on rising edge
// - i_rst_n          in   1                 asynchronous active-low reset
// - i_in_valid       in   1                 input beat valid
// - o_in_ready       out  1                 input beat ready
// - i_in_first       in   1                 beat is first of a block; i_in_scale is sampled only on such beats
// - i_in_scale       in   SCALE_W           shared scale
// - i_in_data        in   LANES*ELEM_W      lane k = element (beat*LANES + k), lane 0 in LSBs
// - o_dp_scale       out  SCALE_W           datapath scale operand (registered)
// - o_dp_elements    out  BLOCK_SIZE*ELEM_W datapath element operands (registered), element 0 in LSBs
// - i_dp_float32     in   32                datapath FP32 result
// - i_dp_overflow    in   1                 datapath overflow flag
// - i_dp_is_unused   in   1                 datapath "some element == 8'h80" flag
// - o_out_valid      out  1                 result valid
// - i_out_ready      in   1                 result accepted
// - o_out_float32    out  32                registered result
// - o_out_overflow   out  1                 registered overflow
// - o_out_is_unused  out  1                 registered unused flag
// - o_err_framing    out  1                 one-cycle pulse on a framing error
// BEHAVIOUR
// - Reset (async assert, sync deassert): state IDLE, beat_cnt = 0, scale/element buffer = 0.
//   All outputs 0, except o_in_ready = 1 once in IDLE.
// - FSM IDLE -> LOAD -> SUM -> HOLD -> IDLE. o_in_ready = 1 in IDLE/LOAD only.
//   A beat is accepted when i_in_valid & o_in_ready.
// - IDLE, accepted beat with i_in_first = 1: latch scale, write lanes into slots 0..LANES-1, beat_cnt = 1.
//   Next state is LOAD, or SUM if BEATS == 1.
// - IDLE, accepted beat with i_in_first = 0: beat dropped, o_err_framing pulses, stay IDLE.
// - LOAD, accepted beat with i_in_first = 0: write slots beat_cnt*LANES..+LANES-1, beat_cnt++.
//   The beat with beat_cnt == BEATS-1 moves to SUM.
// - LOAD, accepted beat with i_in_first = 1: o_err_framing pulses, partial block is discarded.
//   The beat restarts collection (scale latched, slots 0..LANES-1, beat_cnt = 1).
//   Stale upper slots are overwritten before use.
// - SUM (exactly 1 cycle): buffer is stable on o_dp_*; i_dp_* captured into o_out_* at cycle end.
//   Then HOLD with o_out_valid = 1.
// - HOLD: o_out_valid and o_out_* held stable until i_out_ready = 1, then o_out_valid = 0 and return to IDLE.
//   No input is accepted in HOLD.
// - Latency: last beat accepted at edge N -> SUM during cycle N..N+1 -> o_out_valid = 1 after edge N+1.
//   Minimum block period BEATS + 2 cycles.
// - beat_cnt width = clog2(BEATS)+1; it never wraps within a block and is cleared on entry to SUM.
// - o_dp_* change only on accepted beats. No combinational path exists from i_dp_* to any output or from
//   i_out_ready to o_in_ready.
// - Reset mid-operation aborts immediately: partial block lost, pending result dropped, o_out_valid = 0.
// CONFIGURATION
// - MXINT8_SEQ_BLK_CNT_EN defined:
//   - adds output o_blk_count [15:0], reset 0;
//   - increments by 1 on each output handshake (o_out_valid & i_out_ready);
//   - wraps 16'hFFFF -> 0;
//   - not incremented by framing-dropped blocks.
// - MXINT8_SEQ_BLK_CNT_EN undefined: the port and counter do not exist; all other behaviour is identical.
// TESTING (BLOCK_SIZE=32, LANES=4, BEATS=8, real mxint8_sum attached)
// - Scale 8'h7F, all elements 8'h01, 8 back-to-back beats, i_out_ready = 1 ->
//   o_out_float32 = 32'h3F00_0000, overflow 0, unused 0; o_out_valid 2 edges after the last beat.
// - Scale 8'hFF, any elements -> o_out_float32 = 32'h7F80_0001.
// - Scale 8'h7F, all elements 8'h00 -> 32'h0000_0000.
// - Scale 8'h7F, element 17 = 8'h80, others 8'h00 -> o_out_is_unused = 1.
// - i_out_ready = 0 for 5 cycles in HOLD -> o_out_* stable, o_in_ready = 0, no beat accepted.
//   After ready is raised, return to IDLE with o_in_ready = 1 the next cycle.
// - i_in_first = 1 on beat 3 of a block ->
//   - one-cycle o_err_framing pulse;
//   - result reflects only the new block;
//   - a first-less beat in IDLE also pulses o_err_framing.
// - Assert i_rst_n = 0 mid-LOAD (beat 5) -> all outputs 0 asynchronously.
//   The next full block sums correctly. With MXINT8_SEQ_BLK_CNT_EN, 3 blocks -> o_blk_count = 3.

Source files
------------

// File: rtl/mxint8_block_seq.sv
// mxint8_block_seq: sequencer in front of the combinational MXINT8 block-sum datapath.
// Assembles one MX block (shared scale + BLOCK_SIZE elements) from LANES-wide beats,
// holds it on the datapath operands for one SUM cycle, registers the FP32 result and
// presents it on a valid/ready output channel.
// Optional feature macro: MXINT8_SEQ_BLK_CNT_EN adds o_blk_count, a 16-bit wrapping
// count of output handshakes.
module mxint8_block_seq #(
    parameter int unsigned BLOCK_SIZE = 32,
    parameter int unsigned LANES      = 4,
    parameter int unsigned ELEM_W     = 8,
    parameter int unsigned SCALE_W    = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic                         i_in_first,
    input  logic [SCALE_W-1:0]           i_in_scale,
    input  logic [LANES*ELEM_W-1:0]      i_in_data,
    output logic [SCALE_W-1:0]           o_dp_scale,
    output logic [BLOCK_SIZE*ELEM_W-1:0] o_dp_elements,
    input  logic [31:0]                  i_dp_float32,
    input  logic                         i_dp_overflow,
    input  logic                         i_dp_is_unused,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [31:0]                  o_out_float32,
    output logic                         o_out_overflow,
    output logic                         o_out_is_unused,
    output logic                         o_err_framing
`ifdef MXINT8_SEQ_BLK_CNT_EN
    ,
    output logic [15:0]                  o_blk_count
`endif
);

    localparam int unsigned BEATS  = BLOCK_SIZE / LANES;
    localparam int unsigned BEAT_W = LANES * ELEM_W;
    localparam int unsigned CNT_W  = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SUM  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] beat_cnt;

    logic accept_c;
    logic last_beat_c;
    logic wr_first_c;
    logic wr_next_c;
    logic err_c;
    logic capture_c;
    logic in_ready_nxt;
    logic out_valid_nxt;

    assign accept_c    = i_in_valid & o_in_ready;
    assign last_beat_c = (beat_cnt == CNT_W'(BEATS - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a first-flagged beat always restarts collection
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_c && i_in_first) begin
                    state_nxt = (BEATS == 1) ? ST_SUM : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept_c) begin
                    if (i_in_first) begin
                        state_nxt = (BEATS == 1) ? ST_SUM : ST_LOAD;
                    end else if (last_beat_c) begin
                        state_nxt = ST_SUM;
                    end
                end
            end
            ST_SUM:  state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (i_out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output/strobe decode; registered outputs get their next values here
    always_comb begin
        wr_first_c    = 1'b0;
        wr_next_c     = 1'b0;
        err_c         = 1'b0;
        capture_c     = 1'b0;
        out_valid_nxt = 1'b0;
        in_ready_nxt  = (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD);
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    wr_first_c = i_in_first;
                    err_c      = ~i_in_first;
                end
            end
            ST_LOAD: begin
                if (accept_c) begin
                    wr_first_c = i_in_first;
                    wr_next_c  = ~i_in_first;
                    err_c      = i_in_first;
                end
            end
            ST_SUM: begin
                capture_c     = 1'b1;
                out_valid_nxt = 1'b1;
            end
            ST_HOLD: begin
                out_valid_nxt = ~i_out_ready;
            end
            default: ;
        endcase
    end

    // Handshake and error flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_in_ready    <= 1'b0;
            o_out_valid   <= 1'b0;
            o_err_framing <= 1'b0;
        end else begin
            o_in_ready    <= in_ready_nxt;
            o_out_valid   <= out_valid_nxt;
            o_err_framing <= err_c;
        end
    end

    // Operand buffer: scale plus element slots, written only by accepted beats
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dp_scale    <= '0;
            o_dp_elements <= '0;
            beat_cnt      <= '0;
        end else begin
            if (wr_first_c) begin
                o_dp_scale                 <= i_in_scale;
                o_dp_elements[BEAT_W-1:0]  <= i_in_data;
                beat_cnt                   <= CNT_W'((BEATS == 1) ? 0 : 1);
            end else if (wr_next_c) begin
                for (int unsigned b = 0; b < BEATS; b++) begin
                    if (beat_cnt == CNT_W'(b)) begin
                        o_dp_elements[b*BEAT_W +: BEAT_W] <= i_in_data;
                    end
                end
                beat_cnt <= last_beat_c ? '0 : beat_cnt + CNT_W'(1);
            end
        end
    end

    // Result capture at the end of the SUM cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_float32   <= '0;
            o_out_overflow  <= 1'b0;
            o_out_is_unused <= 1'b0;
        end else if (capture_c) begin
            o_out_float32   <= i_dp_float32;
            o_out_overflow  <= i_dp_overflow;
            o_out_is_unused <= i_dp_is_unused;
        end
    end

`ifdef MXINT8_SEQ_BLK_CNT_EN
    // Delivered-block counter, wraps naturally at 16 bits
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_blk_count <= '0;
        end else if (o_out_valid && i_out_ready) begin
            o_blk_count <= o_blk_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mxint8_block_seq.sv
// Directed bench for mxint8_block_seq with a behavioural stand-in for mxint8_sum.
module tb_mxint8_block_seq;

    localparam int unsigned BS    = 32;
    localparam int unsigned LN    = 4;
    localparam int unsigned EW    = 8;
    localparam int unsigned SW    = 8;
    localparam int unsigned BEATS = BS / LN;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b1;
    logic              i_in_valid = 1'b0;
    logic              o_in_ready;
    logic              i_in_first = 1'b0;
    logic [SW-1:0]     i_in_scale = '0;
    logic [LN*EW-1:0]  i_in_data = '0;
    logic [SW-1:0]     o_dp_scale;
    logic [BS*EW-1:0]  o_dp_elements;
    logic [31:0]       i_dp_float32;
    logic              i_dp_overflow;
    logic              i_dp_is_unused;
    logic              o_out_valid;
    logic              i_out_ready = 1'b1;
    logic [31:0]       o_out_float32;
    logic              o_out_overflow;
    logic              o_out_is_unused;
    logic              o_err_framing;
`ifdef MXINT8_SEQ_BLK_CNT_EN
    logic [15:0]       o_blk_count;
`endif

    mxint8_block_seq #(
        .BLOCK_SIZE(BS), .LANES(LN), .ELEM_W(EW), .SCALE_W(SW)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_in_valid     (i_in_valid),
        .o_in_ready     (o_in_ready),
        .i_in_first     (i_in_first),
        .i_in_scale     (i_in_scale),
        .i_in_data      (i_in_data),
        .o_dp_scale     (o_dp_scale),
        .o_dp_elements  (o_dp_elements),
        .i_dp_float32   (i_dp_float32),
        .i_dp_overflow  (i_dp_overflow),
        .i_dp_is_unused (i_dp_is_unused),
        .o_out_valid    (o_out_valid),
        .i_out_ready    (i_out_ready),
        .o_out_float32  (o_out_float32),
        .o_out_overflow (o_out_overflow),
        .o_out_is_unused(o_out_is_unused),
        .o_err_framing  (o_err_framing)
`ifdef MXINT8_SEQ_BLK_CNT_EN
        ,
        .o_blk_count    (o_blk_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;
    int blk_sent = 0;
    logic [33:0] exp_q[$];

    // MXINT8 block sum: elements are 1.6 fixed point, scale is a biased power of two.
    // Returns {overflow, is_unused, float32}.
    function automatic logic [33:0] model_sum(input logic [7:0] sc, input logic [BS*EW-1:0] el);
        int s;
        int m;
        int p;
        int e;
        logic un;
        logic sg;
        logic [7:0] x;
        logic [22:0] man;
        s = 0;
        un = 1'b0;
        for (int i = 0; i < int'(BS); i++) begin
            x = el[i*EW +: EW];
            if (x == 8'h80) un = 1'b1;
            else s += int'($signed(x));
        end
        if (sc == 8'hFF) return {1'b0, un, 32'h7F80_0001};
        if (s == 0) return {1'b0, un, 32'h0};
        sg = (s < 0);
        m = sg ? -s : s;
        p = 0;
        for (int i = 0; i < 16; i++) if (m >= (1 << i)) p = i;
        e = p + int'(sc) - 6;
        if (e >= 255) return {1'b1, un, sg, 8'hFF, 23'h0};
        if (e <= 0) return {1'b0, un, sg, 31'h0};
        man = 23'((m << (23 - p)) & 32'h007F_FFFF);
        return {1'b0, un, sg, 8'(e), man};
    endfunction

    assign {i_dp_overflow, i_dp_is_unused, i_dp_float32} = model_sum(o_dp_scale, o_dp_elements);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [BS*EW-1:0] act, input logic [BS*EW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result checker: every cycle the output is valid it must equal the oldest expected result
    always @(negedge i_clk) begin
        if (i_rst_n && o_out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL result: got valid %h with no expected result pending", o_out_float32);
            end else begin
                chk("result", 64'({o_out_overflow, o_out_is_unused, o_out_float32}), 64'(exp_q[0]));
            end
        end
    end

    // Retire expected results on output handshakes
    always @(posedge i_clk) begin
        if (i_rst_n && o_out_valid && i_out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(o_in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(o_out_valid), 64'd0);
        chk({tag, "_err"}, 64'(o_err_framing), 64'd0);
        chk({tag, "_dp_scale"}, 64'(o_dp_scale), 64'd0);
        chk_wide({tag, "_dp_elem"}, o_dp_elements, '0);
        chk({tag, "_out"}, 64'({o_out_overflow, o_out_is_unused, o_out_float32}), 64'd0);
`ifdef MXINT8_SEQ_BLK_CNT_EN
        chk({tag, "_blk_count"}, 64'(o_blk_count), 64'd0);
`endif
    endtask

    // Drive one beat from a negedge; returns at the negedge after it is accepted
    task automatic drive_beat(input logic first, input logic [7:0] sc, input logic [31:0] data,
                              input logic exp_err, input string tag);
        int g;
        i_in_valid = 1'b1;
        i_in_first = first;
        i_in_scale = sc;
        i_in_data  = data;
        g = 0;
        while (!o_in_ready && g < 20) begin
            @(negedge i_clk);
            g++;
        end
        if (!o_in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_ready_timeout: got in_ready 0 expected 1 within 20 cycles", tag);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        chk({tag, "_err"}, 64'(o_err_framing), 64'(exp_err));
    endtask

    // Send a full block (optionally after restart_at junk beats) and check latency and handoff
    task automatic send_block(input string tag, input logic [7:0] sc, input logic [BS*EW-1:0] blk,
                              input int restart_at, input int hold);
        for (int b = 0; b < restart_at; b++) begin
            drive_beat(b == 0, 8'h11, 32'h7E7E_7E7E, 1'b0, tag);
        end
        for (int b = 0; b < int'(BEATS); b++) begin
            if (b == int'(BEATS) - 1) exp_q.push_back(model_sum(sc, blk));
            drive_beat(b == 0, sc, blk[b*LN*EW +: LN*EW], (b == 0) && (restart_at > 0), tag);
        end
        i_in_valid = 1'b0;
        blk_sent++;
        chk({tag, "_sum_scale"}, 64'(o_dp_scale), 64'(sc));
        chk_wide({tag, "_sum_elem"}, o_dp_elements, blk);
        chk({tag, "_sum_valid"}, 64'(o_out_valid), 64'd0);
        chk({tag, "_sum_ready"}, 64'(o_in_ready), 64'd0);
        if (hold > 0) begin
            i_out_ready = 1'b0;
            @(negedge i_clk);
            chk({tag, "_lat_valid"}, 64'(o_out_valid), 64'd1);
            i_in_valid = 1'b1;
            i_in_first = 1'b1;
            i_in_scale = 8'h33;
            i_in_data  = 32'hA5A5_A5A5;
            for (int c = 0; c < hold; c++) begin
                @(negedge i_clk);
                chk({tag, "_hold_valid"}, 64'(o_out_valid), 64'd1);
                chk({tag, "_hold_ready"}, 64'(o_in_ready), 64'd0);
                chk_wide({tag, "_hold_elem"}, o_dp_elements, blk);
            end
            i_in_valid  = 1'b0;
            i_out_ready = 1'b1;
            @(negedge i_clk);
        end else begin
            @(negedge i_clk);
            chk({tag, "_lat_valid"}, 64'(o_out_valid), 64'd1);
            @(negedge i_clk);
        end
        chk({tag, "_done_valid"}, 64'(o_out_valid), 64'd0);
        chk({tag, "_done_ready"}, 64'(o_in_ready), 64'd1);
    endtask

    logic [BS*EW-1:0] blk;
    logic [BS*EW-1:0] ones;
    logic [BS*EW-1:0] zeros;
    logic [7:0]       prev_scale;

    initial begin
        for (int i = 0; i < int'(BS); i++) begin
            ones[i*EW +: EW]  = 8'h01;
            zeros[i*EW +: EW] = 8'h00;
        end

        // Hand-computed anchors for the model
        chk("pin_ones", 64'(model_sum(8'h7F, ones)), 64'({2'b00, 32'h3F00_0000}));
        chk("pin_nan", 64'(model_sum(8'hFF, ones)), 64'({2'b00, 32'h7F80_0001}));
        chk("pin_zero", 64'(model_sum(8'h7F, zeros)), 64'({2'b00, 32'h0000_0000}));
        blk = zeros;
        blk[17*EW +: EW] = 8'h80;
        chk("pin_unused", 64'(model_sum(8'h7F, blk)), 64'({2'b01, 32'h0000_0000}));
        blk = zeros;
        blk[0 +: EW] = 8'hC0;
        chk("pin_neg", 64'(model_sum(8'h80, blk)), 64'({2'b00, 32'hC000_0000}));

        // Reset state
        #2 i_rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("post_reset_ready", 64'(o_in_ready), 64'd1);

        send_block("ones", 8'h7F, ones, 0, 0);
        chk("ones_f32", 64'(o_out_float32), 64'h3F00_0000);
        chk("ones_flags", 64'({o_out_overflow, o_out_is_unused}), 64'd0);

        for (int i = 0; i < int'(BS); i++) blk[i*EW +: EW] = 8'(i * 7 + 3);
        send_block("nan", 8'hFF, blk, 0, 0);
        chk("nan_f32", 64'(o_out_float32), 64'h7F80_0001);

        send_block("zero", 8'h7F, zeros, 0, 0);
        chk("zero_f32", 64'(o_out_float32), 64'h0);

        blk = zeros;
        blk[17*EW +: EW] = 8'h80;
        send_block("unused", 8'h7F, blk, 0, 0);
        chk("unused_flag", 64'(o_out_is_unused), 64'd1);

        for (int i = 0; i < int'(BS); i++) blk[i*EW +: EW] = 8'(i - 20);
        send_block("hold", 8'h80, blk, 0, 5);

        for (int i = 0; i < int'(BS); i++) blk[i*EW +: EW] = 8'h7F;
        send_block("ovf", 8'hFE, blk, 0, 0);
        chk("ovf_flag", 64'(o_out_overflow), 64'd1);

        for (int i = 0; i < int'(BS); i++) blk[i*EW +: EW] = 8'(3 * i + 1);
        send_block("restart", 8'h7C, blk, 3, 0);
        @(negedge i_clk);
        chk("restart_err_clear", 64'(o_err_framing), 64'd0);

        // First-less beat in IDLE is dropped with a framing pulse
        prev_scale = o_dp_scale;
        drive_beat(1'b0, 8'h22, 32'h5555_5555, 1'b1, "idle_drop");
        i_in_valid = 1'b0;
        chk("idle_drop_ready", 64'(o_in_ready), 64'd1);
        chk("idle_drop_scale", 64'(o_dp_scale), 64'(prev_scale));
        @(negedge i_clk);
        chk("idle_drop_pulse_end", 64'(o_err_framing), 64'd0);

        // Reset in the middle of a block
        for (int b = 0; b < 5; b++) begin
            drive_beat(b == 0, 8'h7F, 32'h0102_0304, 1'b0, "mid_rst");
        end
        i_in_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1 chk_all_zero("mid_rst");
        exp_q.delete();
        blk_sent = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < int'(BS); i++) blk[i*EW +: EW] = 8'(i);
        send_block("after_rst", 8'h7F, blk, 0, 0);
        chk("after_rst_f32", 64'(o_out_float32), 64'h40F8_0000);
        for (int i = 0; i < int'(BS); i++) blk[i*EW +: EW] = 8'(8'hF0 + 8'(i % 5));
        send_block("neg", 8'h81, blk, 0, 0);
        send_block("ones2", 8'h7F, ones, 0, 0);
`ifdef MXINT8_SEQ_BLK_CNT_EN
        chk("blk_count", 64'(o_blk_count), 64'(blk_sent));
`endif
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
